// File: rtl/mdl_dmaaddrgen_if.sv
// Bus bundle for the multi-channel DMA address generator: timing enables,
// per-channel request/direction/limit inputs and the address/flag outputs.
interface mdl_dmaaddrgen_if #(
  parameter int NCH  = 2,
  parameter int AW   = 11,
  parameter int OUTW = 7
);
  // Request semantics: i_CH_INC[n] is a level, not a pulse handshake. It is
  // consumed on every tick it is high (directly, or one tick later on latched
  // channels); there is no acknowledge, so the requester deasserts to stop.
  logic                       i_CLK4M_PCEN_n;
  logic [7:0]                 i_ROT8;
  logic                       i_ADDR_RST;
  logic [NCH-1:0]             i_CH_INC;
  logic [NCH-1:0]             i_CH_DIR;
  logic [NCH*AW-1:0]          i_CH_LIMIT;
  logic [OUTW-1:0]            o_AOUT;
  logic [NCH*(AW-OUTW)-1:0]   o_AHI;
  logic [NCH-1:0]             o_TC;
  logic [NCH-1:0]             o_OVF;

  modport master (
    output i_CLK4M_PCEN_n, i_ROT8, i_ADDR_RST, i_CH_INC, i_CH_DIR, i_CH_LIMIT,
    input  o_AOUT, o_AHI, o_TC, o_OVF
  );

  modport slave (
    input  i_CLK4M_PCEN_n, i_ROT8, i_ADDR_RST, i_CH_INC, i_CH_DIR, i_CH_LIMIT,
    output o_AOUT, o_AHI, o_TC, o_OVF
  );
endinterface

// File: rtl/mdl_dmaaddrgen.sv
// NCH independent wrap-limited up/down address counters advancing on the
// ROT8[1] slot of the 4 MHz enable, with a shared low-address output mux.
module mdl_dmaaddrgen #(
  parameter int         NCH        = 2,
  parameter int         AW         = 11,
  parameter int         OUTW       = 7,
  parameter logic [7:0] LATCH_MASK = 8'b0000_0010
) (
  input  logic            i_MCLK,
  input  logic            i_RST_n,
  mdl_dmaaddrgen_if.slave bus
);
  localparam int HW = AW - OUTW;

  logic                en;
  logic                tick;
  logic [AW-1:0]       cnt_q [NCH];
  logic [AW-1:0]       cnt_d [NCH];
  logic [AW-1:0]       lim   [NCH];
  logic [NCH-1:0]      lat_q, lat_d;
  logic [NCH-1:0]      ovf_q, ovf_d;
  logic [NCH-1:0]      eff;
  logic [OUTW-1:0]     aout_c;
  logic [NCH*HW-1:0]   ahi_c;
  logic [NCH-1:0]      tc_c;
  logic                unused_rot;

  assign en         = ~bus.i_CLK4M_PCEN_n;
  assign tick       = en & bus.i_ROT8[1];
  assign unused_rot = ^{bus.i_ROT8[7:2], bus.i_ROT8[0]};

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      lim[n] = bus.i_CH_LIMIT[n*AW +: AW];
      // Latched channels act on the request captured at the previous tick.
      eff[n] = LATCH_MASK[n] ? lat_q[n] : bus.i_CH_INC[n];
    end
  end

  always_comb begin
    for (int n = 0; n < NCH; n++) cnt_d[n] = cnt_q[n];
    lat_d = lat_q;
    ovf_d = ovf_q;
    if (tick) begin
      for (int n = 0; n < NCH; n++) begin
        if (LATCH_MASK[n]) lat_d[n] = bus.i_CH_INC[n];
        if (eff[n]) begin
          if (!bus.i_CH_DIR[n]) begin
            if (cnt_q[n] >= lim[n]) begin
              cnt_d[n] = '0;
              ovf_d[n] = 1'b1;
            end else begin
              cnt_d[n] = cnt_q[n] + AW'(1);
            end
          end else begin
            if ((cnt_q[n] == '0) || (cnt_q[n] > lim[n])) begin
              cnt_d[n] = lim[n];
              ovf_d[n] = 1'b1;
            end else begin
              cnt_d[n] = cnt_q[n] - AW'(1);
            end
          end
        end
      end
    end
    // Address clear wins over any advance but leaves pending latched requests.
    if (en && bus.i_ADDR_RST) begin
      for (int n = 0; n < NCH; n++) cnt_d[n] = '0;
      ovf_d = '0;
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      for (int n = 0; n < NCH; n++) cnt_q[n] <= '0;
      lat_q <= '0;
      ovf_q <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) cnt_q[n] <= cnt_d[n];
      lat_q <= lat_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    aout_c = cnt_q[0][OUTW-1:0];
    ahi_c  = '0;
    tc_c   = '0;
    for (int n = 0; n < NCH; n++) begin
      if (bus.i_CH_INC[n]) aout_c = cnt_q[n][OUTW-1:0];
      ahi_c[n*HW +: HW] = cnt_q[n][AW-1:OUTW];
      tc_c[n] = bus.i_CH_DIR[n] ? (cnt_q[n] == '0) : (cnt_q[n] == lim[n]);
    end
  end

  assign bus.o_AOUT = aout_c;
  assign bus.o_AHI  = ahi_c;
  assign bus.o_TC   = tc_c;
  assign bus.o_OVF  = ovf_q;
endmodule

// File: tb/tb_mdl_dmaaddrgen.sv
// Directed scoreboard bench for mdl_dmaaddrgen (NCH=2, AW=11, OUTW=7, ch1 latched).
module tb_mdl_dmaaddrgen;
  localparam int NCH  = 2;
  localparam int AW   = 11;
  localparam int OUTW = 7;
  localparam int HW   = AW - OUTW;
  localparam int W    = OUTW + NCH*HW + 2*NCH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdl_dmaaddrgen_if #(.NCH(NCH), .AW(AW), .OUTW(OUTW)) bus ();

  mdl_dmaaddrgen #(.NCH(NCH), .AW(AW), .OUTW(OUTW), .LATCH_MASK(8'b0000_0010)) dut (
    .i_MCLK (clk),
    .i_RST_n(rst_n),
    .bus    (bus.slave)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad   = 0;
  event         chk_ev;

  // Expected output vector {o_AOUT, o_AHI, o_TC, o_OVF} from hand-derived counts.
  function automatic logic [W-1:0] mk(logic [AW-1:0] c0, logic [AW-1:0] c1,
                                      logic [1:0] tc, logic [1:0] ovf);
    logic [OUTW-1:0] a;
    a = bus.i_CH_INC[1] ? c1[OUTW-1:0] : c0[OUTW-1:0];
    return {a, c1[AW-1:OUTW], c0[AW-1:OUTW], tc, ovf};
  endfunction

  task automatic expect_now(string n, logic [AW-1:0] c0, logic [AW-1:0] c1,
                            logic [1:0] tc, logic [1:0] ovf);
    exp_q.push_back(mk(c0, c1, tc, ovf));
    name_q.push_back(n);
    -> chk_ev;
    #1;
  endtask

  task automatic cyc(logic [1:0] inc, logic tk, logic pcen_n, logic arst);
    bus.i_CH_INC       = inc;
    bus.i_ROT8         = tk ? 8'h02 : 8'hFD;
    bus.i_CLK4M_PCEN_n = pcen_n;
    bus.i_ADDR_RST     = arst;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: samples DUT outputs whenever the driver announces a sample point.
  initial begin
    logic [W-1:0] act, e;
    string        nm;
    forever begin
      @(chk_ev);
      act = {bus.o_AOUT, bus.o_AHI, bus.o_TC, bus.o_OVF};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample got=%h required=<none>", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL %s got=%h required=%h (aout|ahi|tc|ovf)", nm, act, e);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] c;
    bus.i_CLK4M_PCEN_n = 1'b1;
    bus.i_ROT8         = 8'h00;
    bus.i_ADDR_RST     = 1'b0;
    bus.i_CH_INC       = 2'b00;
    bus.i_CH_DIR       = 2'b00;
    bus.i_CH_LIMIT     = {11'h0FF, 11'h7FF};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_now("reset", 11'h000, 11'h000, 2'b00, 2'b00);
    rst_n = 1'b1;

    // ch0 up through a full 2048-step wrap at limit 0x7FF
    for (int i = 1; i <= 2048; i++) begin
      cyc(2'b01, 1'b1, 1'b0, 1'b0);
      c = AW'(i % 2048);
      expect_now("up_wrap", c, 11'h000, {1'b0, i == 2047}, {1'b0, i == 2048});
    end

    for (int i = 1; i <= 5; i++) begin
      cyc(2'b01, 1'b1, 1'b0, 1'b0);
      expect_now("ch0_pre", AW'(i), 11'h000, 2'b00, 2'b01);
    end

    // ch1 latched: a one-tick pulse advances it on the following tick
    cyc(2'b10, 1'b1, 1'b0, 1'b0);
    expect_now("latch_same_tick", 11'h005, 11'h000, 2'b00, 2'b01);
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    expect_now("latch_next_tick", 11'h005, 11'h001, 2'b00, 2'b01);
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    expect_now("latch_hold", 11'h005, 11'h001, 2'b00, 2'b01);

    // ch0 down from 0 with limit 0x00A
    cyc(2'b00, 1'b1, 1'b0, 1'b1);
    expect_now("addr_rst_a", 11'h000, 11'h000, 2'b00, 2'b00);
    bus.i_CH_DIR = 2'b01;
    bus.i_CH_LIMIT[0 +: AW] = 11'h00A;
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("down_wrap", 11'h00A, 11'h000, 2'b00, 2'b01);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("down_1", 11'h009, 11'h000, 2'b00, 2'b01);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("down_2", 11'h008, 11'h000, 2'b00, 2'b01);

    // limit lowered below the count forces a wrap
    bus.i_CH_DIR = 2'b00;
    bus.i_CH_LIMIT[0 +: AW] = 11'h7FF;
    cyc(2'b00, 1'b1, 1'b0, 1'b1);
    expect_now("addr_rst_b", 11'h000, 11'h000, 2'b00, 2'b00);
    for (int i = 1; i <= 80; i++) begin
      cyc(2'b01, 1'b1, 1'b0, 1'b0);
      expect_now("up_to_50", AW'(i), 11'h000, 2'b00, 2'b00);
    end
    bus.i_CH_LIMIT[0 +: AW] = 11'h040;
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("limit_lowered", 11'h000, 11'h000, 2'b00, 2'b01);

    // address clear vs simultaneous requests; latched ch1 request survives
    cyc(2'b11, 1'b1, 1'b0, 1'b0);
    expect_now("both_req", 11'h001, 11'h000, 2'b00, 2'b01);
    cyc(2'b11, 1'b1, 1'b0, 1'b1);
    expect_now("arst_priority", 11'h000, 11'h000, 2'b00, 2'b00);
    cyc(2'b00, 1'b1, 1'b0, 1'b0);
    expect_now("latched_after_arst", 11'h000, 11'h001, 2'b00, 2'b00);

    // limit 0, slot gating and enable gating
    bus.i_CH_LIMIT[0 +: AW] = 11'h000;
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    expect_now("no_rot_hold", 11'h000, 11'h001, 2'b01, 2'b00);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("limit0_adv", 11'h000, 11'h001, 2'b01, 2'b01);
    bus.i_CH_LIMIT[0 +: AW] = 11'h7FF;
    cyc(2'b01, 1'b1, 1'b1, 1'b1);
    expect_now("pcen_hold", 11'h000, 11'h001, 2'b00, 2'b01);

    // asynchronous reset between clock edges
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("pre_rst_1", 11'h001, 11'h001, 2'b00, 2'b01);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("pre_rst_2", 11'h002, 11'h001, 2'b00, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("async_rst", 11'h000, 11'h000, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2'b01, 1'b1, 1'b1, 1'b0);
    expect_now("release_hold", 11'h000, 11'h000, 2'b00, 2'b00);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("resume_1", 11'h001, 11'h000, 2'b00, 2'b00);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    expect_now("resume_2", 11'h002, 11'h000, 2'b00, 2'b00);

    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdl_dmaaddrgen.md
Name: mdl_dmaaddrgen

Overview:
Parametrised multi-channel DMA address generator, successor to the two-channel bubble-data/error-map counter pair. Provides NCH independent address counters, each with a runtime wrap limit, an up/down direction, an optional one-tick request latch, a terminal-count flag and a sticky wrap flag. All counters advance on the ROT8[1] slot of the 4 MHz clock enable. A shared low-address bus is driven by the active channel; the high address bits of every channel are exported to the load/decode logic.

Parameters:
NCH, 2, number of channels (1..8)
AW, 11, counter width per channel in bits (OUTW+1..16)
OUTW, 7, width of shared low-address bus o_AOUT (A7-A1 by default)
LATCH_MASK, 2'b10, per-channel bit: 1 = increment request is registered one tick before use; 0 = request is used directly

Ports:
i_MCLK  in  1  master clock
i_RST_n  in  1  asynchronous active-low reset
i_CLK4M_PCEN_n  in  1  4 MHz clock enable, active low
i_ROT8  in  8  rotating timing slots; only bit 1 is used
i_ADDR_RST  in  1  synchronous clear of all counters and wrap flags, sampled on enable cycles
i_CH_INC  in  NCH  per-channel advance request
i_CH_DIR  in  NCH  per-channel direction: 0 = up, 1 = down
i_CH_LIMIT  in  NCH*AW  per-channel wrap value, channel n at [n*AW +: AW]
o_AOUT  out  OUTW  low address bits of the selected channel
o_AHI  out  NCH*(AW-OUTW)  high address bits, channel n at [n*(AW-OUTW) +: AW-OUTW]
o_TC  out  NCH  terminal count per channel
o_OVF  out  NCH  sticky wrap flag per channel

Behaviour:
- Reset is asynchronous, active low. On reset: all counters 0, latched requests 0, o_OVF 0. o_AOUT = 0 and o_AHI = 0. o_TC follows the rule below (for up channels, bit n = 1 only if limit n = 0).
- Enable cycle: a posedge of i_MCLK with i_CLK4M_PCEN_n = 0. Tick: an enable cycle with i_ROT8[1] = 1. All state changes only on enable cycles.
- Latch: a channel with LATCH_MASK[n] = 1 samples i_CH_INC[n] on every tick.
- Effective request eff[n]: i_CH_INC[n] for unlatched channels; the latched value for latched channels, so a latched request acts one tick late.
- Counter update on a tick with eff[n] = 1:
  - Up: if cnt >= limit, cnt becomes 0 and o_OVF[n] is set. Otherwise cnt becomes cnt+1.
  - Down: if cnt == 0 or cnt > limit, cnt becomes limit and o_OVF[n] is set. Otherwise cnt becomes cnt-1.
  - Arithmetic is AW-bit unsigned with no carry out.
- A limit lowered below the current count causes a wrap on the next advance. Limit 0 holds the count at 0 and sets o_OVF on every advance.
- i_ADDR_RST = 1 on an enable cycle clears all counters and all o_OVF bits. It has priority over a simultaneous tick advance. It does not clear the latched requests.
- o_TC[n] (combinational): 1 when cnt == limit for up channels, or cnt == 0 for down channels.
- o_AOUT (combinational): cnt[OUTW-1:0] of the highest-indexed channel whose raw i_CH_INC is 1. If no request is asserted, channel 0 drives it.
- o_AHI (combinational): cnt[AW-1:OUTW] for each channel.
- Channels are fully independent; simultaneous advances of several channels are all applied.
- Ticks are only taken while i_ROT8[1] = 1. Enable-inactive cycles hold all state, including across reset release.

Test Plan:
- Reset, then NCH=2 defaults, limit0 = 0x7FF, ch0 up, i_CH_INC=01 for 2048 ticks -> counter returns to 0, o_OVF[0] = 1 after tick 2048, o_TC[0] = 1 between ticks 2047 and 2048, o_AHI bits follow cnt[10:7].
- ch1 latched, limit1 = 0x0FF, pulse i_CH_INC[1] for exactly one tick -> ch1 count 0 -> 1 on the following tick, not the same one. o_AOUT shows ch1 only while i_CH_INC[1] = 1.
- ch0 down, limit0 = 0x00A, start at 0, 3 ticks -> counts 0x00A, 0x009, 0x008. o_OVF[0] is set on the first tick.
- ch0 at 0x050, write limit0 = 0x040, 1 tick -> count 0. o_OVF[0] = 1.
- Both channels requesting with i_ADDR_RST = 1 on the same tick -> both counts 0, o_OVF = 00. The latched ch1 request is still applied on the next tick.
- Assert i_RST_n = 0 asynchronously mid-count, between clock edges -> all counts and flags 0 immediately, without waiting for i_MCLK. Counting resumes from 0 on the first tick after release.
